// File: rtl/irq_arbiter_if.sv
// Core-side interrupt handshake plus the small configuration bus of irq_arbiter.
// The arbiter takes the slave modport; the core/config agent takes the master modport.
interface irq_arbiter_if;
  logic        int_ack;
  logic        int_sign_external;
  logic [7:0]  int_num_external;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;

  modport master (
    output int_ack, cfg_we, cfg_addr, cfg_wdata,
    input  int_sign_external, int_num_external, cfg_rdata
  );

  modport slave (
    input  int_ack, cfg_we, cfg_addr, cfg_wdata,
    output int_sign_external, int_num_external, cfg_rdata
  );
endinterface

// File: rtl/irq_arbiter.sv
// Edge-latching, fixed-priority interrupt arbiter feeding the CPU external interrupt inputs.
// Define IRQ_SYNC_EN to put a 2-flop synchronizer on every irq_in line (edge-to-request T+3).
module irq_arbiter #(
  parameter int         N_IRQ    = 8,
  parameter logic [7:0] VEC_BASE = 8'h20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_in,
  irq_arbiter_if.slave     bus
);
  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW} state_t;

  state_t           state, state_nxt;
  logic [N_IRQ-1:0] mask, pending, irq_prev, irq_s;
  logic [N_IRQ-1:0] rise, eligible, w1c, ack_clr, cur_onehot;
  logic [IDX_W-1:0] cur_idx, cur_idx_nxt, winner;
  logic             sign, sign_nxt;
  logic [7:0]       num, num_nxt;
  logic             ack_take;
  logic             unused_wdata;

`ifdef IRQ_SYNC_EN
  logic [N_IRQ-1:0] sync_q1, sync_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_in;
      sync_q2 <= sync_q1;
    end
  end

  assign irq_s = sync_q2;
`else
  assign irq_s = irq_in;
`endif

  assign rise       = irq_s & ~irq_prev;
  assign eligible   = pending & mask;
  assign cur_onehot = N_IRQ'(1) << cur_idx;
  assign w1c        = (bus.cfg_we && bus.cfg_addr == 2'd1) ? bus.cfg_wdata[N_IRQ-1:0] : '0;
  assign ack_clr    = ack_take ? cur_onehot : '0;
  // Upper write-data bits beyond N_IRQ have no destination.
  assign unused_wdata = ^bus.cfg_wdata;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    winner = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = IDX_W'(i);
    end
  end

  always_comb begin
    state_nxt   = state;
    sign_nxt    = sign;
    num_nxt     = num;
    cur_idx_nxt = cur_idx;
    ack_take    = 1'b0;
    case (state)
      IDLE: begin
        if (|eligible) begin
          cur_idx_nxt = winner;
          num_nxt     = VEC_BASE + 8'(winner);
          sign_nxt    = 1'b1;
          state_nxt   = REQ;
        end
      end
      REQ: begin
        // Vector stays frozen here; a lost mask bit or a W1C of the active source withdraws it.
        if (bus.int_ack) begin
          ack_take  = 1'b1;
          sign_nxt  = 1'b0;
          state_nxt = WAIT_LOW;
        end else if (!mask[cur_idx] || w1c[cur_idx]) begin
          sign_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      WAIT_LOW: begin
        sign_nxt = 1'b0;
        if (!bus.int_ack) state_nxt = IDLE;
      end
      default: begin
        sign_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      state   <= IDLE;
      sign    <= 1'b0;
      num     <= '0;
      cur_idx <= '0;
    end else begin
      state   <= state_nxt;
      sign    <= sign_nxt;
      num     <= num_nxt;
      cur_idx <= cur_idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask     <= '0;
      pending  <= '0;
      irq_prev <= '0;
    end else begin
      irq_prev <= irq_s;
      // A fresh edge beats a same-cycle clear from ack or W1C.
      pending  <= (pending & ~(w1c | ack_clr)) | rise;
      if (bus.cfg_we && bus.cfg_addr == 2'd0) mask <= bus.cfg_wdata[N_IRQ-1:0];
    end
  end

  assign bus.int_sign_external = sign;
  assign bus.int_num_external  = num;

  always_comb begin
    bus.cfg_rdata = '0;
    case (bus.cfg_addr)
      2'd0:    bus.cfg_rdata = 32'(mask);
      2'd1:    bus.cfg_rdata = 32'(pending);
      2'd2:    bus.cfg_rdata = {16'h0, num, 6'h0, state == REQ, state != IDLE};
      default: bus.cfg_rdata = '0;
    endcase
  end
endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the pending/mask/handshake rules.
module tb_irq_arbiter;
`ifdef IRQ_SYNC_EN
  localparam int SYNC_DLY = 2;
`else
  localparam int SYNC_DLY = 0;
`endif
  localparam int PH_IDLE = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_WAIT = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in;

  irq_arbiter_if bus ();

  irq_arbiter #(.N_IRQ(8), .VEC_BASE(8'h20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .irq_in(irq_in),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: what the controller should show after each clock edge.
  bit [7:0] m_mask, m_pend, m_prev, m_s1, m_s2, m_vec;
  bit       m_sign;
  int       m_phase, m_src;

  function automatic int lowest_set(input bit [7:0] v);
    int idx = 0;
    while (idx < 7 && !v[idx]) idx++;
    return idx;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {24'h0, m_mask};
      2'd1:    return {24'h0, m_pend};
      2'd2:    return {16'h0, m_vec, 6'h0, m_phase == PH_REQ, m_phase != PH_IDLE};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit [7:0] seen, clr, wr_clr;
    if (!rst_n) begin
      m_mask = 0; m_pend = 0; m_prev = 0; m_s1 = 0; m_s2 = 0;
      m_vec = 0; m_sign = 0; m_phase = PH_IDLE; m_src = 0;
    end else begin
      wr_clr = (bus.cfg_we && bus.cfg_addr == 2'd1) ? bus.cfg_wdata[7:0] : 8'h00;
      clr    = wr_clr;
`ifdef IRQ_SYNC_EN
      seen = m_s2;
      m_s2 = m_s1;
      m_s1 = irq_in;
`else
      seen = irq_in;
`endif
      case (m_phase)
        PH_IDLE:
          if ((m_pend & m_mask) != 8'h00) begin
            m_src   = lowest_set(m_pend & m_mask);
            m_vec   = 8'(32'h20 + m_src);
            m_sign  = 1'b1;
            m_phase = PH_REQ;
          end
        PH_REQ:
          if (bus.int_ack) begin
            clr[m_src] = 1'b1;
            m_sign     = 1'b0;
            m_phase    = PH_WAIT;
          end else if (!m_mask[m_src] || wr_clr[m_src]) begin
            m_sign  = 1'b0;
            m_phase = PH_IDLE;
          end
        PH_WAIT:
          if (!bus.int_ack) m_phase = PH_IDLE;
        default: m_phase = PH_IDLE;
      endcase
      m_pend = (m_pend & ~clr) | (seen & ~m_prev);
      m_prev = seen;
      if (bus.cfg_we && bus.cfg_addr == 2'd0) m_mask = bus.cfg_wdata[7:0];
    end
  end

  // One clock: drive on the falling edge, compare just after the rising edge.
  task automatic cycle(input logic [7:0] irq, input logic we, input logic [1:0] addr,
                       input logic [31:0] wdata, input logic ack);
    @(negedge clk);
    irq_in        = irq;
    bus.cfg_we    = we;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = wdata;
    bus.int_ack   = ack;
    @(posedge clk);
    #1;
    check("model_sign", 32'(bus.int_sign_external), 32'(m_sign));
    check("model_num", 32'(bus.int_num_external), 32'(m_vec));
    check("model_rdata", bus.cfg_rdata, m_read(addr));
  endtask

  task automatic idle(input int n, input logic [1:0] addr);
    for (int k = 0; k < n; k++) cycle(8'h00, 1'b0, addr, 32'h0, 1'b0);
  endtask

  logic [7:0]  r_irq;
  logic        r_we, r_ack;
  logic [1:0]  r_addr;
  logic [31:0] r_wdata;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    irq_in = 8'h00; bus.cfg_we = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_wdata = 32'h0; bus.int_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_sign", 32'(bus.int_sign_external), 32'h0);
    check("rst_num", 32'(bus.int_num_external), 32'h0);
    check("rst_mask", bus.cfg_rdata, 32'h0);

    // Single source: pending at T, request at T+1, ack for two cycles, then release.
    cycle(8'h00, 1'b1, 2'd0, 32'hFF, 1'b0);
    cycle(8'h08, 1'b0, 2'd1, 32'h0, 1'b0);
    idle(SYNC_DLY, 2'd1);
    check("s1_pend", bus.cfg_rdata, 32'h08);
    check("s1_no_sign_yet", 32'(bus.int_sign_external), 32'h0);
    cycle(8'h00, 1'b0, 2'd2, 32'h0, 1'b0);
    check("s1_sign", 32'(bus.int_sign_external), 32'h1);
    check("s1_num", 32'(bus.int_num_external), 32'h23);
    check("s1_status_req", bus.cfg_rdata, 32'h2303);
    cycle(8'h00, 1'b0, 2'd1, 32'h0, 1'b1);
    check("s1_pend_acked", bus.cfg_rdata, 32'h0);
    check("s1_sign_drop", 32'(bus.int_sign_external), 32'h0);
    cycle(8'h00, 1'b0, 2'd2, 32'h0, 1'b1);
    check("s1_status_wait", bus.cfg_rdata, 32'h2301);
    cycle(8'h00, 1'b0, 2'd2, 32'h0, 1'b0);
    check("s1_status_idle", bus.cfg_rdata, 32'h2300);

    // Two simultaneous edges: lowest index first, the other after WAIT_LOW.
    cycle(8'h22, 1'b0, 2'd1, 32'h0, 1'b0);
    idle(SYNC_DLY, 2'd1);
    check("s2_pend", bus.cfg_rdata, 32'h22);
    cycle(8'h00, 1'b0, 2'd1, 32'h0, 1'b0);
    check("s2_first_vec", 32'(bus.int_num_external), 32'h21);
    cycle(8'h00, 1'b0, 2'd1, 32'h0, 1'b1);
    check("s2_pend_after_ack", bus.cfg_rdata, 32'h20);
    cycle(8'h00, 1'b0, 2'd2, 32'h0, 1'b0);
    check("s2_gap_sign", 32'(bus.int_sign_external), 32'h0);
    cycle(8'h00, 1'b0, 2'd2, 32'h0, 1'b0);
    check("s2_second_sign", 32'(bus.int_sign_external), 32'h1);
    check("s2_second_vec", 32'(bus.int_num_external), 32'h25);
    cycle(8'h00, 1'b0, 2'd1, 32'h0, 1'b1);
    idle(1, 2'd1);

    // Masked source stays pending until enabled; request follows the mask write.
    cycle(8'h00, 1'b1, 2'd0, 32'h00, 1'b0);
    cycle(8'h04, 1'b0, 2'd1, 32'h0, 1'b0);
    idle(SYNC_DLY + 1, 2'd1);
    check("s3_pend", bus.cfg_rdata, 32'h04);
    check("s3_no_req", 32'(bus.int_sign_external), 32'h0);
    cycle(8'h00, 1'b1, 2'd0, 32'h04, 1'b0);
    check("s3_write_cycle", 32'(bus.int_sign_external), 32'h0);
    cycle(8'h00, 1'b0, 2'd2, 32'h0, 1'b0);
    check("s3_req_vec", 32'(bus.int_num_external), 32'h22);
    check("s3_req_sign", 32'(bus.int_sign_external), 32'h1);
    cycle(8'h00, 1'b0, 2'd1, 32'h0, 1'b1);
    idle(1, 2'd1);

    // Masking mid-request withdraws it but keeps the pending bit.
    cycle(8'h00, 1'b1, 2'd0, 32'hFF, 1'b0);
    cycle(8'h40, 1'b0, 2'd1, 32'h0, 1'b0);
    idle(SYNC_DLY + 1, 2'd1);
    check("s4_vec", 32'(bus.int_num_external), 32'h26);
    cycle(8'h00, 1'b1, 2'd0, 32'h00, 1'b0);
    check("s4_sign_held", 32'(bus.int_sign_external), 32'h1);
    cycle(8'h00, 1'b0, 2'd1, 32'h0, 1'b0);
    check("s4_sign_drop", 32'(bus.int_sign_external), 32'h0);
    check("s4_pend_kept", bus.cfg_rdata, 32'h40);
    cycle(8'h00, 1'b0, 2'd2, 32'h0, 1'b0);
    check("s4_status", bus.cfg_rdata, 32'h2600);
    cycle(8'h00, 1'b1, 2'd1, 32'h40, 1'b0);
    cycle(8'h00, 1'b1, 2'd0, 32'hFF, 1'b0);

    // New edge on the acked source in the ack cycle: set wins, re-requested.
    cycle(8'h10, 1'b0, 2'd1, 32'h0, 1'b0);
    cycle(8'h00, 1'b0, 2'd1, 32'h0, 1'b0);
    cycle(8'h10, 1'b0, 2'd1, 32'h0, SYNC_DLY == 0);
    for (int k = 0; k < SYNC_DLY; k++) cycle(8'h00, 1'b0, 2'd1, 32'h0, k == SYNC_DLY - 1);
    check("s5_pend_set_wins", bus.cfg_rdata, 32'h10);
    check("s5_sign_drop", 32'(bus.int_sign_external), 32'h0);
    cycle(8'h00, 1'b0, 2'd2, 32'h0, 1'b0);
    cycle(8'h00, 1'b0, 2'd2, 32'h0, 1'b0);
    check("s5_rereq_sign", 32'(bus.int_sign_external), 32'h1);
    check("s5_rereq_vec", 32'(bus.int_num_external), 32'h24);
    cycle(8'h00, 1'b0, 2'd1, 32'h0, 1'b1);
    idle(1, 2'd1);

    // Level held high sets pending once; after W1C it does not come back until re-armed.
    cycle(8'h00, 1'b1, 2'd0, 32'h00, 1'b0);
    for (int k = 0; k < 10; k++) cycle(8'h01, k == 5, 2'd1, 32'h1, 1'b0);
    check("s5_level_once", bus.cfg_rdata, 32'h00);
    cycle(8'h00, 1'b0, 2'd1, 32'h0, 1'b0);
    cycle(8'h01, 1'b0, 2'd1, 32'h0, 1'b0);
    idle(SYNC_DLY, 2'd1);
    check("s5_rearm", bus.cfg_rdata, 32'h01);
    cycle(8'h00, 1'b1, 2'd1, 32'h01, 1'b0);

    // Asynchronous reset between edges while a request is up.
    cycle(8'h00, 1'b1, 2'd0, 32'hFF, 1'b0);
    cycle(8'h04, 1'b0, 2'd0, 32'h0, 1'b0);
    idle(SYNC_DLY + 1, 2'd0);
    check("s6_req_up", 32'(bus.int_sign_external), 32'h1);
    @(negedge clk);
    irq_in = 8'h00; bus.cfg_we = 1'b0; bus.cfg_addr = 2'd0; bus.int_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("s6_rst_sign", 32'(bus.int_sign_external), 32'h0);
    check("s6_rst_num", 32'(bus.int_num_external), 32'h0);
    check("s6_rst_mask", bus.cfg_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(8'h00, 1'b0, 2'd1, 32'h0, 1'b0);
    check("s6_pend_cleared", bus.cfg_rdata, 32'h0);

    // Randomized traffic against the model.
    r_irq = 8'h00;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) r_irq = r_irq ^ (8'($urandom) & 8'($urandom));
      r_we    = ($urandom_range(0, 9) == 0);
      r_addr  = 2'($urandom);
      r_wdata = $urandom;
      r_ack   = ($urandom_range(0, 99) < (bus.int_sign_external ? 50 : 20));
      cycle(r_irq, r_we, r_addr, r_wdata, r_ack);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
